// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin owner of the 32-bit system bus; optional watchdog under BUS_WATCHDOG_EN
module bus_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_MASTERS-1:0]         req,
    output logic [NUM_MASTERS-1:0]         grant,
    input  logic [NUM_MASTERS-1:0]         m_handshake_1,
    output logic [NUM_MASTERS-1:0]         m_handshake_2,
    output logic                           bus_handshake_1,
    input  logic                           bus_handshake_2,
    output logic                           bus_busy,
    output logic [$clog2(NUM_MASTERS)-1:0] grant_id,
    output logic                           timeout_err,
    output logic [$clog2(NUM_MASTERS)-1:0] timeout_id
);
    localparam int IW = $clog2(NUM_MASTERS);

    typedef enum logic [2:0] {S_IDLE, S_GRANT, S_OWNED, S_RELEASE, S_ABORT} state_t;

    state_t                 state_q, state_d;
    logic [IW-1:0]          grant_id_q, grant_id_d;
    logic [IW-1:0]          last_ptr_q, last_ptr_d;
    logic [IW-1:0]          win;
    logic                   found;
    logic                   expire;
    logic                   hs1;
    logic [NUM_MASTERS-1:0] owner_oh;
    logic [NUM_MASTERS-1:0] abort_mask;
    logic [NUM_MASTERS-1:0] elig;

    assign owner_oh = NUM_MASTERS'(1) << grant_id_q;
    assign hs1      = (state_q == S_OWNED) & m_handshake_1[grant_id_q];
    assign elig     = req & ~abort_mask;

`ifdef BUS_WATCHDOG_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES);

    logic [WW-1:0]          wd_count_q, wd_count_d;
    logic [NUM_MASTERS-1:0] abort_mask_q, abort_mask_d;
    logic                   timeout_err_q, timeout_err_d;
    logic [IW-1:0]          timeout_id_q, timeout_id_d;

    assign expire      = (state_q == S_OWNED) && (hs1 != bus_handshake_2) && (wd_count_q == WW'(TIMEOUT_CYCLES - 1));
    assign abort_mask  = abort_mask_q;
    assign timeout_err = timeout_err_q;
    assign timeout_id  = timeout_id_q;

    // watchdog: count a pending handshake edge while owned; mask an aborted master until it drops req
    always_comb begin
        wd_count_d    = ((state_q == S_OWNED) && (hs1 != bus_handshake_2) && !expire) ? wd_count_q + WW'(1) : '0;
        abort_mask_d  = (abort_mask_q & req) | (expire ? owner_oh : '0);
        timeout_err_d = expire;
        timeout_id_d  = expire ? grant_id_q : timeout_id_q;
    end

    // watchdog registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_count_q    <= '0;
            abort_mask_q  <= '0;
            timeout_err_q <= 1'b0;
            timeout_id_q  <= '0;
        end else begin
            wd_count_q    <= wd_count_d;
            abort_mask_q  <= abort_mask_d;
            timeout_err_q <= timeout_err_d;
            timeout_id_q  <= timeout_id_d;
        end
    end
`else
    logic unused_cfg;

    assign unused_cfg  = (TIMEOUT_CYCLES != 0);
    assign expire      = 1'b0;
    assign abort_mask  = '0;
    assign timeout_err = 1'b0;
    assign timeout_id  = '0;
`endif

    // round-robin search from last_ptr+1; walking downward lets the nearest eligible master win
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            if (elig[(int'(last_ptr_q) + k) % NUM_MASTERS]) begin
                win   = IW'((int'(last_ptr_q) + k) % NUM_MASTERS);
                found = 1'b1;
            end
        end
    end

    // state and bookkeeping registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            grant_id_q <= '0;
            last_ptr_q <= IW'(NUM_MASTERS - 1);
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            last_ptr_q <= last_ptr_d;
        end
    end

    // next state: abort outranks a req drop; release/abort wait for the slave ack to fall
    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        last_ptr_d = last_ptr_q;
        case (state_q)
            S_IDLE: begin
                state_d    = found ? S_GRANT : S_IDLE;
                grant_id_d = found ? win : grant_id_q;
            end
            S_GRANT: begin
                state_d    = S_OWNED;
                last_ptr_d = grant_id_q;
            end
            S_OWNED:   state_d = expire ? S_ABORT : (!req[grant_id_q] ? S_RELEASE : S_OWNED);
            S_RELEASE: state_d = bus_handshake_2 ? S_RELEASE : S_IDLE;
            S_ABORT:   state_d = bus_handshake_2 ? S_ABORT : S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // outputs: grant in turnaround and ownership, strobe and ack routed only while owned
    always_comb begin
        grant           = ((state_q == S_GRANT) || (state_q == S_OWNED)) ? owner_oh : '0;
        bus_handshake_1 = hs1;
        m_handshake_2   = ((state_q == S_OWNED) && bus_handshake_2) ? owner_oh : '0;
        bus_busy        = (state_q != S_IDLE);
        grant_id        = grant_id_q;
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed vectors for bus_arbiter (NUM_MASTERS=4, TIMEOUT_CYCLES=16)
module tb_bus_arbiter;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req = '0;
    logic [3:0] grant;
    logic [3:0] m_handshake_1 = '0;
    logic [3:0] m_handshake_2;
    logic       bus_handshake_1;
    logic       bus_handshake_2 = 1'b0;
    logic       bus_busy;
    logic [1:0] grant_id;
    logic       timeout_err;
    logic [1:0] timeout_id;
    int         n_cmp = 0;
    int         n_err = 0;

    bus_arbiter #(.NUM_MASTERS(4), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .req(req), .grant(grant),
        .m_handshake_1(m_handshake_1), .m_handshake_2(m_handshake_2),
        .bus_handshake_1(bus_handshake_1), .bus_handshake_2(bus_handshake_2),
        .bus_busy(bus_busy), .grant_id(grant_id),
        .timeout_err(timeout_err), .timeout_id(timeout_id)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        logic [3:0] exp_g;
        tick();
        tick();
        reset = 1'b0;
        check("rst_grant", grant, 0);
        check("rst_busy", bus_busy, 0);
        check("rst_id", grant_id, 0);
        check("rst_hs1", bus_handshake_1, 0);
        check("rst_terr", timeout_err, 0);

        // single master M0, three handshakes
        req = 4'b0001;
        m_handshake_1 = 4'b0001;
        tick();
        check("t1_grant", grant, 4'b0001);
        check("t1_hs1_turn", bus_handshake_1, 0);
        check("t1_busy", bus_busy, 1);
        tick();
        check("t1_hs1_live", bus_handshake_1, 1);
        for (int i = 0; i < 3; i++) begin
            m_handshake_1 = 4'b0001;
            #1 check("t1_hs1_hi", bus_handshake_1, 1);
            bus_handshake_2 = 1'b1;
            #1 check("t1_mhs2", m_handshake_2, 4'b0001);
            m_handshake_1 = 4'b0000;
            #1 check("t1_hs1_lo", bus_handshake_1, 0);
            bus_handshake_2 = 1'b0;
            tick();
            check("t1_hold", grant, 4'b0001);
        end
        req = 4'b0000;
        tick();
        check("t1_rel_grant", grant, 0);
        check("t1_rel_busy", bus_busy, 1);
        tick();
        check("t1_idle_busy", bus_busy, 0);
        check("t1_idle_id", grant_id, 0);

        // all four requesting: rotation 0,1,2,3,0
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            exp_g = 4'b0001 << (i % 4);
            tick();
            check("t2_grant", grant, exp_g);
            check("t2_id", grant_id, i % 4);
            tick();
            m_handshake_1 = exp_g;
            #1 check("t2_hs1", bus_handshake_1, 1);
            bus_handshake_2 = 1'b1;
            #1 check("t2_mhs2", m_handshake_2, exp_g);
            m_handshake_1 = 4'b0000;
            bus_handshake_2 = 1'b0;
            req = 4'b1111 & ~exp_g;
            tick();
            check("t2_rel", grant, 0);
            req = 4'b1111;
            tick();
            check("t2_idle", bus_busy, 0);
        end

        // M2 owns, M1 waits without pre-emption
        req = 4'b0100;
        tick();
        tick();
        req = 4'b0110;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_hold", grant, 4'b0100);
        end
        req = 4'b0010;
        bus_handshake_2 = 1'b1;
        tick();
        check("t3_rel", grant, 0);
        tick();
        check("t3_wait_busy", bus_busy, 1);
        check("t3_wait_grant", grant, 0);
        bus_handshake_2 = 1'b0;
        tick();
        check("t3_idle", bus_busy, 0);
        tick();
        check("t3_m1", grant, 4'b0010);

        // M1 drops req mid-strobe while slave acks
        tick();
        m_handshake_1 = 4'b0010;
        bus_handshake_2 = 1'b1;
        req = 4'b0000;
        #1 check("t4_hs1", bus_handshake_1, 1);
        tick();
        check("t4_grant", grant, 0);
        check("t4_cut", bus_handshake_1, 0);
        check("t4_mhs2", m_handshake_2, 0);
        tick();
        check("t4_stay", bus_busy, 1);
        bus_handshake_2 = 1'b0;
        m_handshake_1 = 4'b0000;
        tick();
        check("t4_idle", bus_busy, 0);
        check("t4_id", grant_id, 1);

`ifdef BUS_WATCHDOG_EN
        // M3 strobes, slave never acks
        req = 4'b1000;
        tick();
        tick();
        m_handshake_1 = 4'b1000;
        for (int i = 0; i < 15; i++) tick();
        check("t5_pre_grant", grant, 4'b1000);
        check("t5_pre_terr", timeout_err, 0);
        tick();
        check("t5_terr", timeout_err, 1);
        check("t5_tid", timeout_id, 3);
        check("t5_grant", grant, 0);
        tick();
        check("t5_pulse", timeout_err, 0);
        tick();
        check("t5_masked", bus_busy, 0);
        req = 4'b0000;
        m_handshake_1 = 4'b0000;
        tick();
        req = 4'b1000;
        tick();
        check("t5_regrant", grant, 4'b1000);
        req = 4'b0000;
        tick();
        tick();
        tick();
        check("t5_end", bus_busy, 0);
`else
        check("t5_terr_tied", timeout_err, 0);
        check("t5_tid_tied", timeout_id, 0);
`endif

        // reset while M2 strobes
        req = 4'b0100;
        tick();
        tick();
        m_handshake_1 = 4'b0100;
        bus_handshake_2 = 1'b1;
        #1 check("t6_pre_hs1", bus_handshake_1, 1);
        check("t6_pre_id", grant_id, 2);
        reset = 1'b1;
        tick();
        check("t6_grant", grant, 0);
        check("t6_hs1", bus_handshake_1, 0);
        check("t6_mhs2", m_handshake_2, 0);
        check("t6_busy", bus_busy, 0);
        check("t6_id", grant_id, 0);
        reset = 1'b0;
        m_handshake_1 = 4'b0000;
        bus_handshake_2 = 1'b0;
        req = 4'b1111;
        tick();
        check("t6_ptr", grant, 4'b0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
